// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM state encoding,
// slave word addresses and the default build-time expected values.
package sysid_pkg;

  // Check sequence states; the encoding is also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } sysid_state_e;

  // Word addresses inside the system-ID control slave.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Default values the slave is expected to return.
  localparam logic [31:0] SYSID_DEFAULT_ID      = 32'd890010046;
  localparam logic [31:0] SYSID_DEFAULT_TS      = 32'd1219088571;
  localparam int unsigned SYSID_DEFAULT_TIMEOUT = 255;

  // Stall counter width; covers the full 1..65535 timeout range.
  localparam int unsigned SYSID_CNT_W = 16;

  // True in the two states that own an outstanding Avalon read.
  function automatic logic sysid_is_read_state(input sysid_state_e s);
    return (s == ST_RD_ID) || (s == ST_RD_TS);
  endfunction

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the ID and timestamp words from the
// system-ID slave, compares them with build-time values and reports the
// verdict. A per-read stall limit turns a hung slave into a timeout report.
//
// Handshake: a read is outstanding while master_read=1; it completes in the
// cycle where master_waitrequest=0 and master_readdata is captured in that
// same cycle. While master_waitrequest=1 the address and read strobe hold.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYCLES     = SYSID_DEFAULT_TIMEOUT,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         master_address,
  output logic         master_read,
  input  logic         master_waitrequest,
  input  logic [31:0]  master_readdata,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         id_match,
  output logic         ts_match,
  output logic         timeout,
  output logic [31:0]  read_id,
  output logic [31:0]  read_timestamp,
  output sysid_state_e dbg_state
);

  // Counter value at which one more stalled cycle exhausts the budget.
  localparam logic [SYSID_CNT_W-1:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  sysid_state_e           r_state;
  logic                   r_first;
  logic [SYSID_CNT_W-1:0] r_cnt;
  logic                   r_read;
  logic                   r_addr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_id_match;
  logic                   r_ts_match;
  logic                   r_timeout;
  logic [31:0]            r_read_id;
  logic [31:0]            r_read_ts;

  logic w_in_read;
  logic w_accept;
  logic w_stall;
  logic w_expire;
  logic w_launch;

  // Read completion, stall and expiry qualifiers for the current cycle.
  always_comb begin
    w_in_read = sysid_is_read_state(r_state);
    w_accept  = w_in_read & ~master_waitrequest;
    w_stall   = w_in_read & master_waitrequest;
    w_expire  = w_stall & (r_cnt == TO_LAST);
  end

  // Launch request: the first cycle after reset uses AUTO_START only, so a
  // start pulse coincident with reset release never causes a second launch.
  always_comb begin
    w_launch = 1'b0;
    if (r_state == ST_IDLE) begin
      w_launch = r_first ? AUTO_START : start;
    end else if (r_state == ST_DONE) begin
      w_launch = start;
    end
  end

  // Check sequence FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_first    <= 1'b1;
      r_cnt      <= '0;
      r_read     <= 1'b0;
      r_addr     <= SYSID_ADDR_ID;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_timeout  <= 1'b0;
      r_read_id  <= '0;
      r_read_ts  <= '0;
    end else begin
      r_first <= 1'b0;
      if (w_launch) begin
        // Fresh run: every result from the previous run is wiped here.
        r_state    <= ST_RD_ID;
        r_read     <= 1'b1;
        r_addr     <= SYSID_ADDR_ID;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_pass     <= 1'b0;
        r_id_match <= 1'b0;
        r_ts_match <= 1'b0;
        r_timeout  <= 1'b0;
        r_read_id  <= '0;
        r_read_ts  <= '0;
        r_cnt      <= '0;
      end else begin
        case (r_state)
          ST_RD_ID, ST_RD_TS: begin
            if (w_accept) begin
              r_cnt <= '0;
              if (r_state == ST_RD_ID) begin
                // Timestamp read follows immediately, no idle cycle.
                r_read_id <= master_readdata;
                r_addr    <= SYSID_ADDR_TS;
                r_state   <= ST_RD_TS;
              end else begin
                r_read_ts <= master_readdata;
                r_read    <= 1'b0;
                r_addr    <= SYSID_ADDR_ID;
                r_state   <= ST_CHECK;
              end
            end else if (w_expire) begin
              // Abandon the read; an already captured ID word still gets
              // its match flag, the uncaptured word keeps flag and value 0.
              r_read     <= 1'b0;
              r_addr     <= SYSID_ADDR_ID;
              r_timeout  <= 1'b1;
              r_pass     <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_id_match <= (r_state == ST_RD_TS) && (r_read_id == EXPECTED_ID);
              r_state    <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            r_id_match <= (r_read_id == EXPECTED_ID);
            r_ts_match <= (r_read_ts == EXPECTED_TIMESTAMP);
            r_pass     <= (r_read_id == EXPECTED_ID) &&
                          (r_read_ts == EXPECTED_TIMESTAMP);
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
          default: begin
            // IDLE waits for a launch; DONE holds results until start.
          end
        endcase
      end
    end
  end

  assign master_address = r_addr;
  assign master_read    = r_read;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign id_match       = r_id_match;
  assign ts_match       = r_ts_match;
  assign timeout        = r_timeout;
  assign read_id        = r_read_id;
  assign read_timestamp = r_read_ts;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: power-on auto start, a table of directed slave
// behaviours, ignored start pulses, async reset mid-stall, and randomized
// slave behaviour checked against an arithmetic reference model.
module tb_sysid_checker;
  import sysid_pkg::*;

  localparam logic [31:0] EID = 32'd890010046;
  localparam logic [31:0] ETS = 32'd1219088571;
  localparam int          TO  = 8;
  localparam int          RW  = 70;   // {done,pass,idm,tsm,to,busy,rid,rts}
  localparam int          NV  = 10;
  localparam int          NR  = 25;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         master_waitrequest = 1'b0;
  logic [31:0]  master_readdata = '0;
  logic         master_address;
  logic         master_read;
  logic         busy;
  logic         done;
  logic         pass;
  logic         id_match;
  logic         ts_match;
  logic         timeout;
  logic [31:0]  read_id;
  logic [31:0]  read_timestamp;
  sysid_state_e dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  // Slave behaviour knobs and observation state.
  int          slv_stall_id, slv_stall_ts, slv_used, slv_reads;
  logic [31:0] slv_data_id, slv_data_ts;
  logic        prev_stall = 1'b0;
  logic        prev_addr = 1'b0;

  typedef struct {
    int          sid;
    int          sts;
    logic [31:0] did;
    logic [31:0] dts;
    int          exp_cyc;
    int          exp_reads;
    logic [RW-1:0] exp_res;
  } vec_t;
  vec_t tbl[NV];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sysid_checker #(
    .EXPECTED_ID        (EID),
    .EXPECTED_TIMESTAMP (ETS),
    .TIMEOUT_CYCLES     (TO),
    .AUTO_START         (1'b1)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .master_address     (master_address),
    .master_read        (master_read),
    .master_waitrequest (master_waitrequest),
    .master_readdata    (master_readdata),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .id_match           (id_match),
    .ts_match           (ts_match),
    .timeout            (timeout),
    .read_id            (read_id),
    .read_timestamp     (read_timestamp),
    .dbg_state          (dbg_state)
  );

  // ---------------- helpers ----------------
  function automatic logic [RW-1:0] pack_obs();
    return {done, pass, id_match, ts_match, timeout, busy, read_id, read_timestamp};
  endfunction

  function automatic logic [RW-1:0] mk(input logic p, input logic im, input logic tm,
                                       input logic t, input logic [31:0] rid,
                                       input logic [31:0] rts);
    return {1'b1, p, im, tm, t, 1'b0, rid, rts};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one sequence from the slave's stall counts.
  function automatic void model(input int sid, input int sts, input logic [31:0] did,
                                input logic [31:0] dts, output int cyc,
                                output int nreads, output logic [RW-1:0] res);
    logic [31:0] rid, rts;
    logic        idm, tsm, t;
    rid = '0; rts = '0; idm = 1'b0; tsm = 1'b0; t = 1'b0;
    if (sid >= TO) begin
      t = 1'b1; cyc = 1 + TO; nreads = 0;
    end else begin
      rid = did;
      idm = (did == EID);
      if (sts >= TO) begin
        t = 1'b1; cyc = sid + 2 + TO; nreads = 1;
      end else begin
        rts = dts;
        tsm = (dts == ETS);
        cyc = sid + sts + 4;
        nreads = 2;
      end
    end
    res = mk(idm & tsm & ~t, idm, tsm, t, rid, rts);
  endfunction

  // ---------------- driver tasks ----------------
  // Zero-latency slave, called once per cycle just after the clock edge.
  task automatic slave_drive();
    if (prev_stall) begin
      if (master_read) check("hold_addr", RW'(master_address), RW'(prev_addr));
      else             check("drop_only_on_timeout", RW'(timeout), RW'(1'b1));
    end
    if (master_read) begin
      int budget;
      budget = master_address ? slv_stall_ts : slv_stall_id;
      if (slv_used < budget) begin
        master_waitrequest = 1'b1;
        master_readdata    = $urandom;
        slv_used++;
      end else begin
        master_waitrequest = 1'b0;
        master_readdata    = master_address ? slv_data_ts : slv_data_id;
        slv_used = 0;
        slv_reads++;
      end
      prev_stall = master_waitrequest;
      prev_addr  = master_address;
    end else begin
      master_waitrequest = 1'b0;
      master_readdata    = $urandom;
      slv_used   = 0;
      prev_stall = 1'b0;
    end
  endtask

  // Runs one sequence; cycle 0 is the current cycle, start pulses at cycles
  // flagged in ign_mask are applied while the sequence is in flight.
  task automatic run_seq(input bit pulse, input int sid, input int sts,
                         input logic [31:0] did, input logic [31:0] dts,
                         input logic [31:0] ign_mask, output int done_cyc,
                         output logic [RW-1:0] obs);
    slv_stall_id = sid; slv_stall_ts = sts;
    slv_data_id  = did; slv_data_ts  = dts;
    slv_reads = 0;
    if (pulse) start = 1'b1;
    done_cyc = -1;
    obs = '0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      logic [4:0] ci;
      @(posedge clk); #1;
      ci = cyc[4:0];
      start = (cyc < 32) && ign_mask[ci];
      slave_drive();
      if (cyc == 1) begin
        check("first_rd_id_flags", pack_obs(), {6'b000001, 64'd0});
        check("first_rd_id_strobe", RW'({master_read, master_address}), RW'(2'b10));
      end
      if (done) begin
        done_cyc = cyc;
        obs = pack_obs();
        break;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      n_vec++; n_err++;
      $display("FAIL done_seen: no done within 200 cycles");
      obs = pack_obs();
    end
  endtask

  // Runs a sequence and scores it through the expected queue.
  task automatic run_and_score(input string name, input bit pulse, input int sid,
                               input int sts, input logic [31:0] did,
                               input logic [31:0] dts, input logic [31:0] mask,
                               input int ecyc, input int ereads,
                               input logic [RW-1:0] eres);
    int            cyc;
    logic [RW-1:0] obs;
    exp_q.push_back(eres);
    run_seq(pulse, sid, sts, did, dts, mask, cyc, obs);
    check({name, "_cycle"}, RW'(cyc), RW'(ecyc));
    check({name, "_reads"}, RW'(slv_reads), RW'(ereads));
    check({name, "_result"}, obs, exp_q.pop_front());
  endtask

  // Holds start low and confirms no read is launched and done holds.
  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      slave_drive();
      check(name, RW'({master_read, done}), RW'(2'b01));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int            ecyc, ereads;
    logic [RW-1:0] eres;
    int            sid, sts;
    logic [31:0]   did, dts;

    tbl[0] = '{0,  0,  EID,           ETS,                 4,  2, mk(1, 1, 1, 0, EID, ETS)};
    tbl[1] = '{0,  0,  EID,           32'h12345678,        4,  2, mk(0, 1, 0, 0, EID, 32'h12345678)};
    tbl[2] = '{3,  3,  EID,           ETS,                 10, 2, mk(1, 1, 1, 0, EID, ETS)};
    tbl[3] = '{50, 0,  EID,           ETS,                 9,  0, mk(0, 0, 0, 1, 32'd0, 32'd0)};
    tbl[4] = '{0,  0,  EID,           ETS,                 4,  2, mk(1, 1, 1, 0, EID, ETS)};
    tbl[5] = '{2,  50, 32'hDEADBEEF,  ETS,                 12, 1, mk(0, 0, 0, 1, 32'hDEADBEEF, 32'd0)};
    tbl[6] = '{0,  7,  EID,           ETS,                 11, 2, mk(1, 1, 1, 0, EID, ETS)};
    tbl[7] = '{7,  0,  32'd0,         ETS,                 11, 2, mk(0, 0, 1, 0, 32'd0, ETS)};
    tbl[8] = '{0,  8,  EID,           ETS,                 10, 1, mk(0, 1, 0, 1, EID, 32'd0)};
    tbl[9] = '{1,  0,  EID,           ETS ^ 32'h80000000,  5,  2, mk(0, 1, 0, 0, EID, ETS ^ 32'h80000000)};

    // Power-on reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", pack_obs(), '0);
    check("rst_strobe", RW'({master_read, master_address}), '0);
    check("rst_state", RW'(dbg_state), RW'(ST_IDLE));

    // Release with start coincident: AUTO_START gives exactly one launch.
    reset_n = 1'b1;
    start   = 1'b1;
    run_and_score("auto_start", 1'b0, 0, 0, EID, ETS, 32'd0, 4, 2, mk(1, 1, 1, 0, EID, ETS));
    idle_check("auto_single_launch", 4);

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      run_and_score($sformatf("vec%0d", i), 1'b1, tbl[i].sid, tbl[i].sts,
                    tbl[i].did, tbl[i].dts, 32'd0,
                    tbl[i].exp_cyc, tbl[i].exp_reads, tbl[i].exp_res);
    end

    // Start pulses during RD_TS (cycle 2) and CHECK (cycle 3) are ignored.
    run_and_score("busy_start", 1'b1, 0, 0, EID, ETS, 32'h0000000C, 4, 2,
                  mk(1, 1, 1, 0, EID, ETS));
    idle_check("busy_start_no_rerun", 4);
    // Rerun from DONE after a mismatching run: flags cleared at first RD_ID.
    run_and_score("rerun_bad", 1'b1, 0, 0, 32'h0BADF00D, ETS, 32'd0, 4, 2,
                  mk(0, 0, 1, 0, 32'h0BADF00D, ETS));
    run_and_score("rerun_good", 1'b1, 1, 2, EID, ETS, 32'd0, 7, 2,
                  mk(1, 1, 1, 0, EID, ETS));

    // Asynchronous reset in the middle of a stalled ID read.
    slv_stall_id = 50; slv_stall_ts = 0; slv_used = 0;
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      slave_drive();
    end
    check("stall_before_rst", RW'({master_read, busy}), RW'(2'b11));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_outputs", pack_obs(), '0);
    check("async_rst_strobe", RW'({master_read, master_address}), '0);
    prev_stall = 1'b0;
    slv_used   = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_and_score("auto_after_rst", 1'b0, 0, 0, EID, ETS, 32'd0, 4, 2,
                  mk(1, 1, 1, 0, EID, ETS));

    // Randomized slave behaviour against the reference model.
    for (int i = 0; i < NR; i++) begin
      sid = $urandom_range(0, 10);
      sts = $urandom_range(0, 10);
      did = ($urandom_range(0, 1) == 1) ? EID : $urandom;
      dts = ($urandom_range(0, 1) == 1) ? ETS : $urandom;
      model(sid, sts, did, dts, ecyc, ereads, eres);
      run_and_score($sformatf("rand%0d", i), 1'b1, sid, sts, did, dts, 32'd0,
                    ecyc, ereads, eres);
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
